// File: rtl/btn_event_queue.sv
// Turns debounced key levels into press/release/auto-repeat events tagged with a switch snapshot,
// queued in a first-word-fall-through FIFO that the CPU pops with rd_en; overflow drops and flags.
module btn_event_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [23:0] REP_DELAY  = 24'd12_500_000,
  parameter logic [23:0] REP_PERIOD = 24'd2_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  button,
  input  logic [7:0]  SW,
  input  logic        rd_en,
  input  logic        clr_ovf,
  output logic        ev_valid,
  output logic [12:0] ev_data,
  output logic [4:0]  ev_count,
  output logic        ovf
);

  localparam int unsigned PW = $clog2(DEPTH);

  function automatic logic [2:0] enc5(input logic [4:0] m);
    enc5 = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (m[i]) enc5 = 3'(i);
    end
  endfunction

  logic [4:0]    b_q, press_pend_q, press_pend_d, rel_pend_q, rel_pend_d;
  logic          rep_pend_q, rep_pend_d, rep_armed_q, rep_armed_d;
  logic [23:0]   rep_cnt_q, rep_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [12:0]   mem [DEPTH];

  logic [4:0]  press_lsb, rel_lsb, pp_clr, rp_clr;
  logic        key_stable, key_onehot, rep_active, rep_hit, rep_take;
  logic [23:0] rep_thr;
  logic        push, pop, full, wr, drop;
  logic [12:0] ev_new;

  // Event arbitration: press beats release beats repeat; lowest key index first.
  always_comb begin
    press_lsb  = press_pend_q & (~press_pend_q + 5'd1);
    rel_lsb    = rel_pend_q & (~rel_pend_q + 5'd1);
    key_stable = (button == b_q);
    key_onehot = $onehot(b_q);
    rep_active = key_onehot && (press_pend_q == 5'd0);
    rep_thr    = rep_armed_q ? (REP_PERIOD - 24'd1) : (REP_DELAY - 24'd1);
    rep_hit    = rep_active && (rep_cnt_q == rep_thr);

    push     = 1'b0;
    ev_new   = 13'd0;
    pp_clr   = 5'd0;
    rp_clr   = 5'd0;
    rep_take = 1'b0;
    if (press_pend_q != 5'd0) begin
      push   = 1'b1;
      ev_new = {SW, 2'b00, enc5(press_lsb)};
      pp_clr = press_lsb;
    end else if (rel_pend_q != 5'd0) begin
      push   = 1'b1;
      ev_new = {SW, 2'b01, enc5(rel_lsb)};
      rp_clr = rel_lsb;
    end else if (rep_pend_q || rep_hit) begin
      push     = 1'b1;
      ev_new   = {SW, 2'b10, enc5(b_q)};
      rep_take = 1'b1;
    end

    press_pend_d = (press_pend_q & ~pp_clr) | (button & ~b_q);
    rel_pend_d   = (rel_pend_q & ~rp_clr) | (~button & b_q);
  end

  // Repeat timer restarts on any key change; a repeat that loses arbitration is parked one cycle.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_pend_d  = rep_pend_q;
    if (!key_stable || !key_onehot) begin
      rep_cnt_d   = 24'd0;
      rep_armed_d = 1'b0;
      rep_pend_d  = 1'b0;
    end else begin
      if (rep_cnt_q == rep_thr) begin
        if (rep_active) begin
          rep_cnt_d   = 24'd0;
          rep_armed_d = 1'b1;
        end
      end else begin
        rep_cnt_d = rep_cnt_q + 24'd1;
      end
      if (rep_take) begin
        rep_pend_d = 1'b0;
      end else if (rep_hit) begin
        rep_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    pop      = rd_en && (count_q != 5'd0);
    full     = (count_q == 5'(DEPTH));
    wr       = push && (!full || pop);
    drop     = push && full && !pop;
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (wr && !pop) begin
      count_d = count_q + 5'd1;
    end else if (pop && !wr) begin
      count_d = count_q - 5'd1;
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q          <= 5'd0;
      press_pend_q <= 5'd0;
      rel_pend_q   <= 5'd0;
      rep_pend_q   <= 1'b0;
      rep_armed_q  <= 1'b0;
      rep_cnt_q    <= 24'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= 5'd0;
      ovf_q        <= 1'b0;
    end else begin
      b_q          <= button;
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      rep_pend_q   <= rep_pend_d;
      rep_armed_q  <= rep_armed_d;
      rep_cnt_q    <= rep_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible through the occupancy-gated output mux.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= ev_new;
  end

  assign ev_valid = (count_q != 5'd0);
  assign ev_data  = ev_valid ? mem[rd_ptr_q] : 13'd0;
  assign ev_count = count_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_btn_event_queue.sv
// Directed bench for btn_event_queue with short repeat timing (delay 10, period 4) and DEPTH 4.
module tb_btn_event_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  button;
  logic [7:0]  SW;
  logic        rd_en, clr_ovf;
  logic        ev_valid, ovf;
  logic [12:0] ev_data;
  logic [4:0]  ev_count;
  int tests_run = 0;
  int tests_failed = 0;

  btn_event_queue #(.DEPTH(4), .REP_DELAY(24'd10), .REP_PERIOD(24'd4)) dut (
    .clk(clk), .rst_n(rst_n), .button(button), .SW(SW), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_count(ev_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; button = 5'd0; rd_en = 1'b0; clr_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; button = 5'd0; SW = 8'hFF; rd_en = 1'b0; clr_ovf = 1'b0;
    #3;
    tests_run++;
    if ({ev_valid, ev_data, ev_count, ovf} !== 20'd0) begin
      tests_failed++; $display("FAIL reset_outputs got %h expected 0", {ev_valid, ev_data, ev_count, ovf});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    tests_run++;
    if ({ev_valid, ev_count, ovf} !== 7'd0) begin
      tests_failed++; $display("FAIL idle_after_reset got %h expected 0", {ev_valid, ev_count, ovf});
    end
  endtask

  task automatic test_press_release();
    do_reset();
    SW = 8'hA5; button = 5'b00001;
    tick();
    tests_run++;
    if (ev_count !== 5'd0) begin
      tests_failed++; $display("FAIL pr_latency count got %0d expected 0", ev_count);
    end
    tick();
    tests_run++;
    if (ev_valid !== 1'b1 || ev_count !== 5'd1 || ev_data !== 13'h14A0) begin
      tests_failed++; $display("FAIL pr_press got v%b c%0d d%h expected v1 c1 d14a0", ev_valid, ev_count, ev_data);
    end
    tick();
    button = 5'b00000;
    tick(); tick();
    tests_run++;
    if (ev_count !== 5'd2 || ev_data !== 13'h14A0) begin
      tests_failed++; $display("FAIL pr_two_events got c%0d d%h expected c2 d14a0", ev_count, ev_data);
    end
    pop_one();
    tests_run++;
    if (ev_count !== 5'd1 || ev_data !== 13'h14A8) begin
      tests_failed++; $display("FAIL pr_release got c%0d d%h expected c1 d14a8", ev_count, ev_data);
    end
    pop_one();
    tests_run++;
    if (ev_valid !== 1'b0 || ev_count !== 5'd0 || ev_data !== 13'd0) begin
      tests_failed++; $display("FAIL pr_empty got v%b c%0d d%h expected 0 0 0", ev_valid, ev_count, ev_data);
    end
    pop_one();
    tests_run++;
    if (ev_count !== 5'd0) begin
      tests_failed++; $display("FAIL pr_pop_empty got c%0d expected 0", ev_count);
    end
  endtask

  task automatic test_multi_press();
    logic [12:0] exp_d [3];
    exp_d[0] = 13'h781; exp_d[1] = 13'h782; exp_d[2] = 13'h784;
    do_reset();
    SW = 8'h3C; button = 5'b10110;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests_run++;
    if (ev_count !== 5'd1 || ev_data !== 13'h781) begin
      tests_failed++; $display("FAIL mp_push_pop_empty got c%0d d%h expected c1 d781", ev_count, ev_data);
    end
    tick(); tick();
    tests_run++;
    if (ev_count !== 5'd3) begin
      tests_failed++; $display("FAIL mp_count got %0d expected 3", ev_count);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ev_data !== exp_d[i]) begin
        tests_failed++; $display("FAIL mp_order[%0d] got %h expected %h", i, ev_data, exp_d[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_repeat();
    int          ev_e [16];
    logic [12:0] ev_d [16];
    int          exp_e [7];
    logic [12:0] exp_d [7];
    int          nev = 0;
    exp_e[0] = 1;  exp_d[0] = 13'h003;
    exp_e[1] = 10; exp_d[1] = 13'h013;
    exp_e[2] = 14; exp_d[2] = 13'h013;
    exp_e[3] = 18; exp_d[3] = 13'h013;
    exp_e[4] = 22; exp_d[4] = 13'h013;
    exp_e[5] = 26; exp_d[5] = 13'h013;
    exp_e[6] = 29; exp_d[6] = 13'h001;
    do_reset();
    SW = 8'h00; button = 5'b01000;
    tick();
    for (int e = 1; e <= 48; e++) begin
      if (e == 28) button = 5'b01010;
      tick();
      rd_en = 1'b0;
      if (ev_valid) begin
        if (nev < 16) begin
          ev_e[nev] = e; ev_d[nev] = ev_data;
        end
        nev++;
        rd_en = 1'b1;
      end
    end
    rd_en = 1'b0;
    tick();
    tests_run++;
    if (nev !== 7) begin
      tests_failed++; $display("FAIL rep_event_count got %0d expected 7", nev);
    end
    for (int i = 0; i < 7; i++) begin
      if (i < nev) begin
        tests_run++;
        if (ev_e[i] !== exp_e[i] || ev_d[i] !== exp_d[i]) begin
          tests_failed++;
          $display("FAIL rep_event[%0d] got edge %0d data %h expected edge %0d data %h", i, ev_e[i], ev_d[i], exp_e[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    SW = 8'h5A; button = 5'b11111;
    tick();
    tick(); tick(); tick(); tick();
    tests_run++;
    if (ev_count !== 5'd4 || ovf !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_full got c%0d o%b expected c4 o0", ev_count, ovf);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tests_run++;
    if (ev_count !== 5'd4 || ovf !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_set_wins got c%0d o%b expected c4 o1", ev_count, ovf);
    end
    tick();
    tests_run++;
    if (ovf !== 1'b1) begin
      tests_failed++; $display("FAIL ovf_sticky got %b expected 1", ovf);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_clear got %b expected 0", ovf);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ev_data !== (13'hB40 + 13'(i)) || ev_count !== 5'(4 - i)) begin
        tests_failed++; $display("FAIL ovf_entry[%0d] got d%h c%0d expected d%h c%0d", i, ev_data, ev_count, 13'hB40 + 13'(i), 4 - i);
      end
      pop_one();
    end
  endtask

  task automatic test_full_push_pop();
    logic [12:0] exp_d [4];
    exp_d[0] = 13'h221; exp_d[1] = 13'h222; exp_d[2] = 13'h223; exp_d[3] = 13'h228;
    do_reset();
    SW = 8'h11; button = 5'b01111;
    tick();
    tick(); tick(); tick(); tick();
    button = 5'b01110;
    tick();
    tests_run++;
    if (ev_count !== 5'd4 || ev_data !== 13'h220) begin
      tests_failed++; $display("FAIL fpp_full got c%0d d%h expected c4 d220", ev_count, ev_data);
    end
    pop_one();
    tests_run++;
    if (ev_count !== 5'd4 || ovf !== 1'b0) begin
      tests_failed++; $display("FAIL fpp_same_edge got c%0d o%b expected c4 o0", ev_count, ovf);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ev_data !== exp_d[i]) begin
        tests_failed++; $display("FAIL fpp_wrap_order[%0d] got %h expected %h", i, ev_data, exp_d[i]);
      end
      pop_one();
    end
    tests_run++;
    if (ev_count !== 5'd0) begin
      tests_failed++; $display("FAIL fpp_drained got c%0d expected 0", ev_count);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    SW = 8'h77; button = 5'b00111;
    tick();
    tick(); tick(); tick();
    tests_run++;
    if (ev_count !== 5'd3) begin
      tests_failed++; $display("FAIL rm_queued got c%0d expected 3", ev_count);
    end
    button = 5'b00100;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ev_valid, ev_data, ev_count, ovf} !== 20'd0) begin
      tests_failed++; $display("FAIL rm_async_clear got %h expected 0", {ev_valid, ev_data, ev_count, ovf});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (ev_count !== 5'd0) begin
      tests_failed++; $display("FAIL rm_latency got c%0d expected 0", ev_count);
    end
    tick();
    tests_run++;
    if (ev_count !== 5'd1 || ev_data !== 13'hEE2) begin
      tests_failed++; $display("FAIL rm_held_press got c%0d d%h expected c1 dee2", ev_count, ev_data);
    end
    tick(); tick(); tick();
    tests_run++;
    if (ev_count !== 5'd1) begin
      tests_failed++; $display("FAIL rm_single_event got c%0d expected 1", ev_count);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_multi_press();
    test_repeat();
    test_overflow();
    test_full_push_pop();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
